// File: rtl/imm_gen_stage.sv
// Immediate generator for RV32I/RV64I formats feeding a DEPTH-entry decode->execute FIFO.
// Both sides use valid/ready handshakes so decode and execute can stall independently.
module imm_gen_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           InstrD,
    input  logic [2:0]            ImmSrcD,
    input  logic                  ValidD,
    output logic                  ReadyD,
    input  logic                  FlushE,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic                  ImmIllegalE,
    output logic                  ValidE,
    input  logic                  ReadyE,
    output logic [CNT_W-1:0]      CountE
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [63:0]         imm_wide;
    logic                illegal;
    logic                s;
    logic [DATA_WIDTH:0] wdata;

    assign s = InstrD[31];

    // Extend to 64 bits once, then truncate to DATA_WIDTH.
    always_comb begin
        imm_wide = '0;
        illegal  = 1'b0;
        case (ImmSrcD)
            3'b000: imm_wide = {{52{s}}, InstrD[31:20]};
            3'b001: imm_wide = {{32{s}}, InstrD[31:12], 12'b0};
            3'b010: imm_wide = {{52{s}}, InstrD[31:25], InstrD[11:7]};
            3'b011: imm_wide = {{52{s}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            3'b100: imm_wide = {{44{s}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            3'b101: begin
                if (DATA_WIDTH == 64) imm_wide = {58'b0, InstrD[25:20]};
                else                  imm_wide = {59'b0, InstrD[24:20]};
            end
            3'b110: imm_wide = {59'b0, InstrD[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    assign wdata = {illegal, imm_wide[DATA_WIDTH-1:0]};

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign ReadyD = (cnt_q < CNT_W'(DEPTH));
    assign ValidE = (cnt_q != '0);
    assign CountE = cnt_q;
    assign push   = ValidD & ReadyD & ~FlushE;
    assign pop    = ValidE & ReadyE;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (FlushE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Explicit wrap: DEPTH need not be a power of two.
            if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
            else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Only entry 0 is reset so the head reads zero out of reset.
    logic [DATA_WIDTH:0] entry0_q;
    logic [DATA_WIDTH:0] mem_q   [DEPTH-1];
    logic [DATA_WIDTH:0] entries [DEPTH];
    logic [DATA_WIDTH:0] head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
        end else if (push && wr_ptr_q == '0) begin
            entry0_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) begin
            if (push && wr_ptr_q == PTR_W'(i)) mem_q[i-1] <= wdata;
        end
    end

    always_comb begin
        entries[0] = entry0_q;
        for (int i = 1; i < DEPTH; i++) entries[i] = mem_q[i-1];
    end

    assign head        = entries[rd_ptr_q];
    assign ImmExtE     = head[DATA_WIDTH-1:0];
    assign ImmIllegalE = head[DATA_WIDTH];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit/DEPTH=2 and a 64-bit/DEPTH=3 instance share stimulus
// and are compared against queue models of the buffer and an arithmetic immediate model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [2:0]  src;
    logic        valid_d, ready_e, flush_e;

    logic        a_ready_d, a_ill, a_valid_e;
    logic [31:0] a_imm;
    logic [1:0]  a_count;
    logic        b_ready_d, b_ill, b_valid_e;
    logic [63:0] b_imm;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;

    typedef logic [64:0] ent_t;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.DATA_WIDTH(32), .DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .InstrD(instr), .ImmSrcD(src), .ValidD(valid_d),
        .ReadyD(a_ready_d), .FlushE(flush_e), .ImmExtE(a_imm), .ImmIllegalE(a_ill),
        .ValidE(a_valid_e), .ReadyE(ready_e), .CountE(a_count)
    );

    imm_gen_stage #(.DATA_WIDTH(64), .DEPTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .InstrD(instr), .ImmSrcD(src), .ValidD(valid_d),
        .ReadyD(b_ready_d), .FlushE(flush_e), .ImmExtE(b_imm), .ImmIllegalE(b_ill),
        .ValidE(b_valid_e), .ReadyE(ready_e), .CountE(b_count)
    );

    // Returns {illegal, 64-bit value}; the 32-bit instance uses the low half.
    function automatic ent_t ref_ext(input logic [31:0] w, input logic [2:0] f, input bit x64);
        longint v;
        bit     ill;
        ill = 1'b0;
        case (f)
            3'd0: v = longint'($signed(w[31:20]));
            3'd1: v = longint'($signed({w[31:12], 12'h000}));
            3'd2: v = longint'($signed({w[31:25], w[11:7]}));
            3'd3: v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            3'd4: v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            3'd5: v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
            3'd6: v = longint'(w[19:15]);
            default: begin
                v   = 0;
                ill = 1'b1;
            end
        endcase
        return {ill, v};
    endfunction

    // Drive one cycle of inputs, advance the models at the edge, sample 1ns later.
    task automatic cycle(input bit vd, input logic [31:0] w, input logic [2:0] f,
                         input bit re, input bit fl);
        bit pa, pb, oa, ob;
        instr   = w;
        src     = f;
        valid_d = vd;
        ready_e = re;
        flush_e = fl;
        @(posedge clk);
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            pa = vd && qa.size() < 2;
            pb = vd && qb.size() < 3;
            oa = re && qa.size() != 0;
            ob = re && qb.size() != 0;
            if (oa) void'(qa.pop_front());
            if (ob) void'(qb.pop_front());
            if (pa) qa.push_back(ref_ext(w, f, 1'b0));
            if (pb) qb.push_back(ref_ext(w, f, 1'b1));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        instr   = '0;
        src     = '0;
        valid_d = 1'b0;
        ready_e = 1'b0;
        flush_e = 1'b0;
        #22;
        checks++; if (a_valid_e !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_valid_e); end
        checks++; if (a_ready_d !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b expected 1", a_ready_d); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_a_count: got %0d expected 0", a_count); end
        checks++; if (a_imm !== 32'h0 || a_ill !== 1'b0) begin errors++; $display("FAIL reset_a_head: got %h/%b expected 0/0", a_imm, a_ill); end
        checks++; if (b_valid_e !== 1'b0 || b_imm !== 64'h0) begin errors++; $display("FAIL reset_b: got valid %b imm %h expected 0/0", b_valid_e, b_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_formats();
        logic [31:0] wv [6] = '{32'hFFF00093, 32'h12345037, 32'h80000037,
                                32'hFE000EE3, 32'hFE000EE3, 32'h03F09093};
        logic [2:0]  fv [6] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd7, 3'd5};
        logic [31:0] ea [6] = '{32'hFFFFFFFF, 32'h12345000, 32'h80000000,
                                32'hFFFFFFFC, 32'h0, 32'h1F};
        logic [63:0] eb [6] = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'hFFFFFFFF80000000,
                                64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h3F};
        bit          ei [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, wv[i], fv[i], 1'b1, 1'b0);
            checks++; if (a_valid_e !== 1'b1 || a_count !== 2'd1) begin errors++; $display("FAIL fmt%0d_a_occ: got valid %b count %0d expected 1/1", i, a_valid_e, a_count); end
            checks++; if (a_imm !== ea[i] || a_ill !== ei[i]) begin errors++; $display("FAIL fmt%0d_a_imm: got %h/%b expected %h/%b", i, a_imm, a_ill, ea[i], ei[i]); end
            checks++; if (b_imm !== eb[i] || b_ill !== ei[i]) begin errors++; $display("FAIL fmt%0d_b_imm: got %h/%b expected %h/%b", i, b_imm, b_ill, eb[i], ei[i]); end
        end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (a_valid_e !== 1'b0 || a_count !== 2'd0) begin errors++; $display("FAIL fmt_drain: got valid %b count %0d expected 0/0", a_valid_e, a_count); end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 3; k++) cycle(1'b1, 32'(k) << 20, 3'd0, 1'b0, 1'b0);
        checks++; if (a_count !== 2'd2 || a_ready_d !== 1'b0) begin errors++; $display("FAIL full_a: got count %0d ready %b expected 2/0", a_count, a_ready_d); end
        checks++; if (a_imm !== 32'd1) begin errors++; $display("FAIL full_a_head: got %h expected 1", a_imm); end
        checks++; if (b_count !== 2'd3 || b_ready_d !== 1'b0) begin errors++; $display("FAIL full_b: got count %0d ready %b expected 3/0", b_count, b_ready_d); end
        cycle(1'b1, 32'd4 << 20, 3'd0, 1'b1, 1'b0);
        checks++; if (a_count !== 2'd1 || a_imm !== 32'd2) begin errors++; $display("FAIL full_pop_a: got count %0d head %h expected 1/2", a_count, a_imm); end
        checks++; if (b_count !== 2'd2 || b_imm !== 64'd2) begin errors++; $display("FAIL full_pop_b: got count %0d head %h expected 2/2", b_count, b_imm); end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (a_valid_e !== 1'b0 || b_imm !== 64'd3) begin errors++; $display("FAIL full_order: got a_valid %b b_head %h expected 0/3", a_valid_e, b_imm); end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (b_count !== 2'd0) begin errors++; $display("FAIL full_drain_b: got %0d expected 0", b_count); end
    endtask

    task automatic test_flush_reset();
        cycle(1'b1, 32'd5 << 20, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'd5 << 20, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'd6 << 20, 3'd0, 1'b1, 1'b1);
        checks++; if (a_count !== 2'd0 || a_valid_e !== 1'b0) begin errors++; $display("FAIL flush_a: got count %0d valid %b expected 0/0", a_count, a_valid_e); end
        checks++; if (b_count !== 2'd0 || b_valid_e !== 1'b0) begin errors++; $display("FAIL flush_b: got count %0d valid %b expected 0/0", b_count, b_valid_e); end
        cycle(1'b1, 32'd7 << 20, 3'd0, 1'b0, 1'b0);
        checks++; if (a_valid_e !== 1'b1 || a_imm !== 32'd7) begin errors++; $display("FAIL refill_a: got valid %b head %h expected 1/7", a_valid_e, a_imm); end
        valid_d = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_valid_e !== 1'b0 || a_count !== 2'd0) begin errors++; $display("FAIL async_rst_a: got valid %b count %0d expected 0/0", a_valid_e, a_count); end
        checks++; if (a_imm !== 32'h0 || a_ready_d !== 1'b1) begin errors++; $display("FAIL async_rst_a_head: got %h ready %b expected 0/1", a_imm, a_ready_d); end
        checks++; if (b_valid_e !== 1'b0) begin errors++; $display("FAIL async_rst_b: got %b expected 0", b_valid_e); end
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            checks++; if (a_count !== 2'(qa.size()) || a_valid_e !== (qa.size() != 0) || a_ready_d !== (qa.size() < 2)) begin
                errors++; $display("FAIL rnd%0d_a_occ: got count %0d valid %b ready %b expected count %0d", n, a_count, a_valid_e, a_ready_d, qa.size());
            end
            checks++; if (b_count !== 2'(qb.size()) || b_valid_e !== (qb.size() != 0) || b_ready_d !== (qb.size() < 3)) begin
                errors++; $display("FAIL rnd%0d_b_occ: got count %0d valid %b ready %b expected count %0d", n, b_count, b_valid_e, b_ready_d, qb.size());
            end
            if (qa.size() != 0) begin
                checks++; if ({a_ill, a_imm} !== {qa[0][64], qa[0][31:0]}) begin errors++; $display("FAIL rnd%0d_a_head: got %b/%h expected %b/%h", n, a_ill, a_imm, qa[0][64], qa[0][31:0]); end
            end
            if (qb.size() != 0) begin
                checks++; if ({b_ill, b_imm} !== qb[0]) begin errors++; $display("FAIL rnd%0d_b_head: got %b/%h expected %b/%h", n, b_ill, b_imm, qb[0][64], qb[0][63:0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_full();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
